// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters, with a bounded lock and a registered read-return pipeline.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

    logic          last_owner;
    logic          locked;
    logic [HW-1:0] hold_cnt;
    logic          rd_pend;
    logic          rd_who;

    logic owner_req;
    logic other_req;
    logic keep;
    logic win_valid;
    logic win_id;
    logic win_lock;
    logic win_we;

    always_comb begin
        owner_req = last_owner ? m1_req : m0_req;
        other_req = last_owner ? m0_req : m1_req;
        keep = locked && owner_req &&
               ((hold_cnt < HOLD_TOP) || !other_req);
        win_valid = m0_req | m1_req;
        if (keep)
            win_id = last_owner;
        else if (m0_req && !m1_req)
            win_id = 1'b0;
        else if (m1_req && !m0_req)
            win_id = 1'b1;
        else
            win_id = ~last_owner;
        win_lock = win_id ? m1_lock : m0_lock;
        win_we   = win_id ? m1_we : m0_we;
    end

    assign m0_gnt = win_valid & ~win_id;
    assign m1_gnt = win_valid & win_id;

    // Idle port drives zeros so the RAM sees no stray writes.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (win_valid) begin
            ram_we   = win_we;
            ram_addr = win_id ? m1_addr : m0_addr;
            ram_din  = win_id ? m1_wdata : m0_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= 1'b1;
            locked     <= 1'b0;
            hold_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_who     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (win_valid) begin
                last_owner <= win_id;
                locked     <= win_lock;
                if (win_id == last_owner && locked)
                    hold_cnt <= (hold_cnt == HOLD_TOP) ?
                                hold_cnt : hold_cnt + 1'b1;
                else
                    hold_cnt <= '0;
            end else begin
                locked   <= 1'b0;
                hold_cnt <= '0;
            end
            // Stage 1 tracks the read in flight; stage 2 captures dout.
            rd_pend   <= win_valid & ~win_we;
            rd_who    <= win_id;
            m0_rvalid <= rd_pend & ~rd_who;
            m1_rvalid <= rd_pend & rd_who;
            if (rd_pend && !rd_who)
                m0_rdata <= ram_dout;
            if (rd_pend && rd_who)
                m1_rdata <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM
// (1-cycle read latency, read-before-write on the same edge).
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 0, m0_lock = 0, m0_we = 0;
    logic [4:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [4:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;
    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_HOLD(4)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we)
            mem[ram_addr] <= ram_din;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_lock = 0; m0_we = 0;
        m1_req = 0; m1_lock = 0; m1_we = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 32'hA000_0000 | i;

        // Reset state, then m0 write/read of address 3
        do_reset();
        @(negedge clk);
        check("rst_m0_rvalid", 32'(m0_rvalid), 0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 0);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_ram_we", 32'(ram_we), 0);
        step();
        m0_req = 1; m0_we = 1; m0_addr = 5'd3; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_m0_gnt", 32'(m0_gnt), 1);
        check("wr_m1_gnt", 32'(m1_gnt), 0);
        check("wr_ram_we", 32'(ram_we), 1);
        check("wr_ram_addr", 32'(ram_addr), 3);
        check("wr_ram_din", ram_din, 32'hDEADBEEF);
        step();
        m0_we = 0;
        @(negedge clk);
        check("rd_m0_gnt", 32'(m0_gnt), 1);
        check("wr_no_rvalid", 32'(m0_rvalid), 0);
        step();
        idle();
        @(negedge clk);
        check("rd_n1_rvalid", 32'(m0_rvalid), 0);
        check("idle_ram_addr", 32'(ram_addr), 0);
        step();
        @(negedge clk);
        check("rd_n2_rvalid", 32'(m0_rvalid), 1);
        check("rd_n2_rdata", m0_rdata, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("rd_n3_rvalid", 32'(m0_rvalid), 0);
        check("rd_hold_rdata", m0_rdata, 32'hDEADBEEF);

        // Both request, no lock: alternate starting with m0
        do_reset();
        for (int k = 0; k < 6; k++) begin
            m0_req = (k < 4); m1_req = (k < 4);
            m0_addr = 5'(4 + k); m1_addr = 5'(4 + k);
            @(negedge clk);
            check($sformatf("rr_m0_gnt_%0d", k), 32'(m0_gnt),
                  32'((k < 4) && (k % 2 == 0)));
            check($sformatf("rr_m1_gnt_%0d", k), 32'(m1_gnt),
                  32'((k < 4) && (k % 2 == 1)));
            check($sformatf("rr_m0_rv_%0d", k), 32'(m0_rvalid),
                  32'((k >= 2) && (k % 2 == 0)));
            check($sformatf("rr_m1_rv_%0d", k), 32'(m1_rvalid),
                  32'((k >= 2) && (k % 2 == 1)));
            if (k >= 2 && k % 2 == 0)
                check($sformatf("rr_m0_rd_%0d", k), m0_rdata,
                      32'hA000_0000 | 32'(k + 2));
            if (k >= 2 && k % 2 == 1)
                check($sformatf("rr_m1_rd_%0d", k), m1_rdata,
                      32'hA000_0000 | 32'(k + 2));
            step();
        end

        // m0 locked against a waiting m1: 4 grants, then forced release
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 5'd5;
        m1_req = 1; m1_addr = 5'd6;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("lk_m0_gnt_%0d", k), 32'(m0_gnt), 32'(k != 4));
            check($sformatf("lk_m1_gnt_%0d", k), 32'(m1_gnt), 32'(k == 4));
            step();
        end
        idle();
        repeat (2) step();

        // m0 locked, m1 idle: no forced release
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 5'd8;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("solo_m0_gnt_%0d", k), 32'(m0_gnt), 1);
            step();
        end
        idle();
        repeat (2) step();

        // m1 write then m0 read of the same address
        do_reset();
        m1_req = 1; m1_addr = 5'd7;
        @(negedge clk);
        check("pre_m1_gnt", 32'(m1_gnt), 1);
        step();
        idle();
        step();
        @(negedge clk);
        check("pre_m1_rvalid", 32'(m1_rvalid), 1);
        check("pre_m1_rdata", m1_rdata, 32'hA000_0007);
        step();
        m1_req = 1; m1_we = 1; m1_addr = 5'd31; m1_wdata = 32'h12345678;
        @(negedge clk);
        check("raw_m1_gnt", 32'(m1_gnt), 1);
        check("raw_ram_we", 32'(ram_we), 1);
        check("raw_ram_addr", 32'(ram_addr), 31);
        step();
        idle();
        m0_req = 1; m0_addr = 5'd31;
        @(negedge clk);
        check("raw_m0_gnt", 32'(m0_gnt), 1);
        check("raw_m1_gnt_off", 32'(m1_gnt), 0);
        step();
        idle();
        @(negedge clk);
        check("raw_n2_rvalid", 32'(m0_rvalid), 0);
        step();
        @(negedge clk);
        check("raw_n3_rvalid", 32'(m0_rvalid), 1);
        check("raw_n3_rdata", m0_rdata, 32'h12345678);
        check("raw_m1_rdata", m1_rdata, 32'hA000_0007);
        check("raw_m1_rvalid", 32'(m1_rvalid), 0);
        step();

        // Reset one cycle after a read grant discards the read
        m0_req = 1; m0_addr = 5'd9;
        @(negedge clk);
        check("rr2_m0_gnt", 32'(m0_gnt), 1);
        step();
        idle();
        reset = 1'b0;
        #1;
        check("ar_m0_rdata", m0_rdata, 0);
        check("ar_m1_rdata", m1_rdata, 0);
        repeat (2) begin
            @(negedge clk);
            check("ar_m0_rvalid", 32'(m0_rvalid), 0);
            step();
        end
        reset = 1'b1;
        m0_req = 1; m1_req = 1; m0_addr = 5'd10; m1_addr = 5'd11;
        @(negedge clk);
        check("post_m0_gnt", 32'(m0_gnt), 1);
        check("post_m1_gnt", 32'(m1_gnt), 0);
        check("post_m0_rvalid", 32'(m0_rvalid), 0);
        check("post_m1_rvalid", 32'(m1_rvalid), 0);
        step();
        @(negedge clk);
        check("post2_m1_gnt", 32'(m1_gnt), 1);
        check("post2_m0_rvalid", 32'(m0_rvalid), 0);
        step();
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Two-requester arbiter that shares one single-port synchronous RAM (1-cycle read latency, write-when-we) between requester 0 (MMIO slot side) and requester 1 (datapath side). It issues at most one RAM access per cycle and grants round-robin. A bounded lock lets one requester hold the port for short bursts. Read data is returned through a registered per-requester pipeline with a valid pulse.

Parameters:
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 5, RAM address width
MAX_HOLD, 4, max consecutive locked grants while the other side is requesting (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
m0_req  input  1  requester 0 access request, held until granted
m0_lock  input  1  requester 0 asks to keep the port next cycle
m0_we  input  1  1=write, 0=read
m0_addr  input  ADDR_WIDTH  access address
m0_wdata  input  DATA_WIDTH  write data
m0_gnt  output  1  access accepted this cycle (combinational)
m0_rvalid  output  1  one-cycle pulse, m0_rdata valid
m0_rdata  output  DATA_WIDTH  registered read data
m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_* for requester 1
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_din  output  DATA_WIDTH  RAM write data
ram_dout  input  DATA_WIDTH  RAM read data, valid the cycle after address

Behaviour:
- Reset (reset=0, async): last_owner=1 (m0 wins the first tie), hold_cnt=0, read pipeline cleared, m*_rvalid=0, m*_rdata=0. Outstanding reads are discarded, with no rvalid after reset release.
- Grant, combinational, at most one gnt per cycle:
  - Locked owner: if the previous cycle's winner had lock=1, still has req=1, and (hold_cnt < MAX_HOLD-1 or the other side has req=0), it wins again.
  - Otherwise, if only one req is high, that requester wins.
  - Otherwise, if both are high, the requester that is not last_owner wins.
  - No req: no gnt.
- RAM mux: with a grant, ram_addr/ram_din/ram_we come from the winner (ram_we = winner's we). Without a grant, ram_we=0, ram_addr=0, ram_din=0.
- Registered state on every granted cycle:
  - last_owner <= winner.
  - hold_cnt <= hold_cnt+1, saturating at MAX_HOLD-1, when winner==last_owner and the winner's lock was 1 last cycle. Otherwise hold_cnt <= 0.
  - No grant: hold_cnt <= 0, last_owner unchanged.
- Forced release: a locked owner that reaches MAX_HOLD consecutive grants while the other side requests loses the next cycle to the other side. It may regain the port the cycle after.
- Read latency: a read granted in cycle N gives RAM dout in N+1. rdata of the winner is loaded at the end of N+1. rvalid pulses high for exactly cycle N+2.
  - Back-to-back reads give back-to-back rvalid pulses, in grant order.
  - The rdata of the other requester is untouched.
- Writes produce no rvalid. rdata holds its last read value until the next read completes.
- Ordering: a write granted in N followed by a read of the same address in N+1 (either requester) returns the new data.
- The gnt of a requester with req=0 is always 0. lock without req is ignored.

Test Plan:
- Reset then m0 writes 0xDEADBEEF @3 alone -> m0_gnt=1 same cycle, ram_we=1, ram_addr=3, no rvalid. m0 then reads @3 -> m0_rvalid pulse 2 cycles after the grant, m0_rdata=0xDEADBEEF.
- m0 and m1 both req continuously, no lock -> grants alternate m0,m1,m0,m1 (m0 first after reset). Each read's rvalid goes to the correct port in order.
- m0 lock=1 continuous reads, m1 req held, MAX_HOLD=4 -> m0 granted 4 consecutive cycles, m1 granted in cycle 5, m0 again in cycle 6.
- m0 lock=1 with m1 idle for 10 cycles -> m0 granted all 10 cycles, no forced release.
- m1 writes 0x12345678 @31 in cycle N, m0 reads @31 in N+1 -> m0_rdata=0x12345678 at N+3. m1_rdata is unchanged.
- Assert reset one cycle after a read grant -> rvalid stays 0, rdata=0. After release, m0 and m1 request simultaneously -> m0 wins first.
